cordic_arbiter: RTL

CORDIC_ARBITER -- requirements
Module: cordic_arbiter

---
 rtl/cordic_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cordic_arbiter.sv
// Two-requester round-robin front end for one shared CORDIC core. The block keeps a
// result buffer per requester and runs a watchdog on the core response.
module cordic_arbiter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_angle,
    output logic             req0_ack,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_angle,
    output logic             req1_ack,
    output logic             res0_valid,
    input  logic             res0_ready,
    output logic [WIDTH-1:0] res0_sin,
    output logic [WIDTH-1:0] res0_cos,
    output logic             res1_valid,
    input  logic             res1_ready,
    output logic [WIDTH-1:0] res1_sin,
    output logic [WIDTH-1:0] res1_cos,
    output logic             core_valid_in,
    output logic [WIDTH-1:0] core_angle,
    input  logic             core_recived,
    input  logic             core_valid_out,
    input  logic [WIDTH-1:0] core_sin,
    input  logic [WIDTH-1:0] core_cos,
    output logic             busy,
    output logic             timeout_err,
    output logic             err_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

    localparam int             CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  WD_LAST = CW'(TIMEOUT - 1);

    state_t        state, state_next;
    logic          owner, ptr;
    logic [CW-1:0] wdog;
    logic          elig0, elig1;
    logic          grant, grant_id, capture, abort;

    // A requester whose result buffer is still occupied is not eligible.
    assign elig0 = req0_valid & ~res0_valid;
    assign elig1 = req1_valid & ~res1_valid;
    assign busy  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next    = state;
        grant         = 1'b0;
        grant_id      = 1'b0;
        capture       = 1'b0;
        abort         = 1'b0;
        core_valid_in = 1'b0;
        case (state)
            IDLE: begin
                if (elig0 | elig1) begin
                    grant      = 1'b1;
                    grant_id   = (elig0 & elig1) ? ptr : elig1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                core_valid_in = 1'b1;
                if (wdog >= WD_LAST) begin
                    abort      = 1'b1;
                    state_next = DRAIN;
                end else if (core_recived | core_valid_out) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // A result arriving on the watchdog's last cycle is still kept.
                if (core_valid_out) begin
                    capture    = 1'b1;
                    state_next = DRAIN;
                end else if (wdog >= WD_LAST) begin
                    abort      = 1'b1;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!core_valid_out) state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            req0_ack    <= 1'b0;
            req1_ack    <= 1'b0;
            res0_valid  <= 1'b0;
            res1_valid  <= 1'b0;
            res0_sin    <= '0;
            res0_cos    <= '0;
            res1_sin    <= '0;
            res1_cos    <= '0;
            core_angle  <= '0;
            owner       <= 1'b0;
            ptr         <= 1'b0;
            wdog        <= '0;
            timeout_err <= 1'b0;
            err_id      <= 1'b0;
        end else begin
            req0_ack    <= 1'b0;
            req1_ack    <= 1'b0;
            timeout_err <= 1'b0;
            if (res0_valid & res0_ready) res0_valid <= 1'b0;
            if (res1_valid & res1_ready) res1_valid <= 1'b0;

            if (grant) begin
                core_angle <= grant_id ? req1_angle : req0_angle;
                owner      <= grant_id;
                ptr        <= ~grant_id;
                wdog       <= '0;
                if (grant_id) req1_ack <= 1'b1;
                else          req0_ack <= 1'b1;
            end else if (state == ISSUE || state == WAIT) begin
                wdog <= wdog + 1'b1;
            end

            // Owner buffer is empty by construction, so this never races its own clear.
            if (capture) begin
                if (owner) begin
                    res1_valid <= 1'b1;
                    res1_sin   <= core_sin;
                    res1_cos   <= core_cos;
                end else begin
                    res0_valid <= 1'b1;
                    res0_sin   <= core_sin;
                    res0_cos   <= core_cos;
                end
            end

            if (abort) begin
                timeout_err <= 1'b1;
                err_id      <= owner;
            end
        end
    end

endmodule
